param_rr_enc: RTL and testbench
===============================

# param_rr_enc

Parameterized round-robin arbiter. It turns a request vector into a registered binary grant index with a valid/ready handshake. It sits directly upstream of `param_dec`: `grant_idx` drives the decoder's `x` input, and the decoder rebuilds the one-hot grant. Fairness is kept by a rotating priority pointer that advances past each accepted grant.

## Interface
- `req_width`, 4: number of requesters. Any value ≥ 2 is legal; it does not have to be a power of two.
- `idx_width`, 2: width of the grant index. Must satisfy 2^`idx_width` ≥ `req_width`. Matches the decoder's `input_width`.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input `req_width`: request vector, bit i = requester i. Sampled every cycle, no handshake per bit.
- `grant_ready` input 1: consumer accepts the current grant.
- `grant_valid` output 1: `grant_idx` holds a valid grant.
- `grant_idx` output `idx_width`: binary index of the granted requester, registered.

## Operation
- Internal state:
  - `ptr`: highest-priority requester, range 0..`req_width`-1.
  - FSM with states IDLE and GRANT.
- Arbitration function `arb(req, ptr)`:
  - Scan candidates (`ptr`+k) mod `req_width` for k = 0..`req_width`-1.
  - Return the first candidate with `req` set.
  - Report "none" if `req` == 0.
- Pointer update on accept: `ptr` ← 0 if `grant_idx` == `req_width`-1, else `grant_idx`+1. The modulo wrap is explicit, so non-power-of-two widths never produce an out-of-range index.
- IDLE:
  - If `req` ≠ 0: register `grant_idx` ← `arb(req, ptr)`, set `grant_valid`, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, `grant_ready` = 0:
  - Hold `grant_idx` and `grant_valid`. Changes on `req`, including withdrawal of the granted bit, are ignored.
- GRANT, `grant_ready` = 1 (handshake):
  - Update `ptr` as above.
  - In the same cycle, evaluate `arb(req, ptr_next)` using the current `req`.
  - If a requester is found: load the new `grant_idx` and stay in GRANT with `grant_valid` = 1, giving back-to-back grants.
  - Otherwise: clear `grant_valid`, go to IDLE.
- `ptr` changes only on a handshake. Nothing else moves it.
- `grant_idx` keeps its last value while in IDLE. Its value is don't-care when `grant_valid` = 0, but must never exceed `req_width`-1.
- `grant_ready` is ignored in IDLE.

## Timing
- Reset values, applied asynchronously as soon as `rst_n` = 0:
  - `grant_valid` = 0, `grant_idx` = 0, `ptr` = 0, state = IDLE.
- Release: the first edge with `rst_n` = 1 performs normal IDLE evaluation.
- Latency: `req` ≠ 0 sampled at edge n in IDLE → `grant_valid` = 1 after edge n, i.e. one cycle. There is no combinational path from `req` to the outputs.
- Throughput: one grant per cycle while `grant_ready` = 1 and `req` ≠ 0.
- Handshake rules:
  - A transfer occurs on an edge where `grant_valid` & `grant_ready` = 1.
  - `grant_idx` is stable from the assertion of `grant_valid` until the transfer.
  - `grant_valid` never drops without a transfer, except on reset.
- Simultaneous accept and `req` change: arbitration uses the `req` value sampled at the accept edge.
- Reset mid-grant: the pending grant is discarded. It is not re-issued unless `req` is still asserted after release, and then it is re-arbitrated from `ptr` = 0.
- Single requester: with `req` = only bit j and `grant_ready` = 1, `grant_idx` = j is granted every cycle. The pointer wraps past j and returns to it.

## Test plan
- Reset: drive `rst_n` = 0 mid-cycle while in GRANT with `grant_ready` = 0 → `grant_valid` = 0 and `grant_idx` = 0 immediately, without a clock edge. After release with `req` = 4'b1000, the first grant is `idx` 3.
- Full rotation: `req` = 4'b1111, `grant_ready` = 1 held → `grant_idx` sequence 0,1,2,3,0,1 on consecutive cycles, with `grant_valid` continuously 1 after the first edge.
- Sparse fairness: `req` = 4'b1010, `grant_ready` = 1 → `grant_idx` 1,3,1,3. Then `req` = 4'b0001 → next grant 0, then 0 repeated.
- Backpressure and withdrawal: `req` = 4'b0100 for one cycle, then `req` = 0, `grant_ready` = 0 for 3 cycles → `grant_idx` = 2 held with `grant_valid` = 1. Then `grant_ready` = 1 for one cycle → transfer, `grant_valid` = 0 on the next cycle, FSM in IDLE.
- Non-power-of-two: `req_width` = 3, `idx_width` = 2, `req` = 3'b111, `grant_ready` = 1 → `grant_idx` 0,1,2,0,1. The value 3 never appears.
- Idle gap: `req` = 0 for 5 cycles after granting `idx` 1 → `grant_valid` = 0 throughout. Then `req` = 4'b0011 → grant 0, because `ptr` = 2 wraps to 0.

Source files
------------

// File: rtl/param_rr_enc.sv
// param_rr_enc: round-robin arbiter producing a registered binary grant index
// with a valid/ready handshake. A rotating priority pointer moves past every
// accepted grant, so each requester is served in turn.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   req         - request vector, bit i = requester i
//   grant_ready - consumer accepts the current grant
//   grant_valid - grant_idx holds a valid grant
//   grant_idx   - binary index of the granted requester (registered)

// Combinational arb(req, ptr): first set request scanning from ptr upward,
// wrapping modulo req_width. One candidate slot per priority position k.
module param_rr_enc_arb #(
  parameter int req_width = 4,
  parameter int idx_width = 2
) (
  input  logic [req_width-1:0] req,
  input  logic [idx_width-1:0] ptr,
  output logic                 found,
  output logic [idx_width-1:0] idx
);
  localparam logic [idx_width:0] RW = (idx_width+1)'(req_width);

  logic [req_width-1:0][idx_width-1:0] cand;
  logic [req_width-1:0]                hit;
  // seen[k]: some candidate at priority 0..k-1 already hit
  logic [req_width:0]                  seen;
  logic [req_width:0][idx_width-1:0]   acc;

  assign seen[0] = 1'b0;
  assign acc[0]  = '0;

  for (genvar k = 0; k < req_width; k++) begin : g_slot
    logic [idx_width:0] sum;
    // ptr + k < 2*req_width, so a single conditional subtract wraps it
    assign sum       = {1'b0, ptr} + (idx_width+1)'(k);
    assign cand[k]   = (sum >= RW) ? idx_width'(sum - RW) : sum[idx_width-1:0];
    assign hit[k]    = req[cand[k]];
    assign seen[k+1] = seen[k] | hit[k];
    assign acc[k+1]  = acc[k] | ({idx_width{hit[k] & ~seen[k]}} & cand[k]);
  end

  assign found = seen[req_width];
  assign idx   = acc[req_width];
endmodule

module param_rr_enc #(
  parameter int req_width = 4,
  parameter int idx_width = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [req_width-1:0] req,
  input  logic                 grant_ready,
  output logic                 grant_valid,
  output logic [idx_width-1:0] grant_idx
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [idx_width-1:0] idx_q, idx_d;
  logic [idx_width-1:0] ptr_q, ptr_d;
  logic [idx_width-1:0] ptr_adv;
  logic                 found_cur, found_adv;
  logic [idx_width-1:0] arb_cur, arb_adv;

  // Pointer after accepting idx_q; explicit wrap keeps non-power-of-two
  // widths in range.
  assign ptr_adv = (idx_q == idx_width'(req_width-1)) ? '0 : idx_q + 1'b1;

  // Fresh arbitration from the current pointer (IDLE)
  param_rr_enc_arb #(.req_width(req_width), .idx_width(idx_width)) u_arb_cur (
    .req(req), .ptr(ptr_q), .found(found_cur), .idx(arb_cur)
  );

  // Back-to-back arbitration from the post-accept pointer (GRANT + ready)
  param_rr_enc_arb #(.req_width(req_width), .idx_width(idx_width)) u_arb_adv (
    .req(req), .ptr(ptr_adv), .found(found_adv), .idx(arb_adv)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found_cur) begin
          idx_d   = arb_cur;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Without ready the grant is frozen, whatever req does
        if (grant_ready) begin
          ptr_d = ptr_adv;
          if (found_adv) idx_d   = arb_adv;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_idx   = idx_q;
endmodule

// File: tb/tb_param_rr_enc.sv
module tb_param_rr_enc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req4 = '0;
  logic       rdy4 = 1'b0;
  logic       vld4;
  logic [1:0] idx4;
  logic [2:0] req3 = '0;
  logic       rdy3 = 1'b0;
  logic       vld3;
  logic [1:0] idx3;

  int n_tests = 0;
  int n_fail  = 0;
  int q4[$];
  int q3[$];

  always #5 clk = ~clk;

  param_rr_enc #(.req_width(4), .idx_width(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .grant_ready(rdy4),
    .grant_valid(vld4), .grant_idx(idx4)
  );

  param_rr_enc #(.req_width(3), .idx_width(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .grant_ready(rdy3),
    .grant_valid(vld3), .grant_idx(idx3)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every transfer (valid & ready) pops one expected index
  always @(negedge clk) begin
    if (rst_n && vld4 && rdy4) begin
      if (q4.size() == 0) chk("w4_unexpected_grant", int'(idx4), -1);
      else chk("w4_grant_idx", int'(idx4), q4.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && vld3 && rdy3) begin
      if (q3.size() == 0) chk("w3_unexpected_grant", int'(idx3), -1);
      else chk("w3_grant_idx", int'(idx3), q3.pop_front());
    end
  end

  initial begin
    #1;
    chk("reset_valid", int'(vld4), 0);
    chk("reset_idx", int'(idx4), 0);
    #12 rst_n = 1'b1;
    step();

    // Full rotation: 0,1,2,3,0,1
    req4 = 4'b1111; rdy4 = 1'b1;
    q4.push_back(0); q4.push_back(1); q4.push_back(2);
    q4.push_back(3); q4.push_back(0); q4.push_back(1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rot_valid", int'(vld4), 1);
    end
    // accept idx 1 with no requests -> IDLE, ptr = 2
    req4 = '0;
    step();

    // Idle gap
    for (int i = 0; i < 5; i++) begin
      chk("idle_valid", int'(vld4), 0);
      step();
    end
    req4 = 4'b0011; q4.push_back(0);
    step();
    chk("wrap_valid", int'(vld4), 1);

    // Sparse fairness, then single requester
    req4 = 4'b1010;
    q4.push_back(1); q4.push_back(3); q4.push_back(1); q4.push_back(3);
    repeat (4) step();
    req4 = 4'b0001; q4.push_back(0); q4.push_back(0);
    repeat (2) step();
    req4 = '0;
    step();
    chk("single_to_idle", int'(vld4), 0);

    // Backpressure and withdrawal (ptr = 1)
    req4 = 4'b0100; rdy4 = 1'b0; q4.push_back(2);
    step();
    req4 = '0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", int'(vld4), 1);
      chk("bp_idx", int'(idx4), 2);
      step();
    end
    rdy4 = 1'b1;
    step();
    chk("bp_after_xfer", int'(vld4), 0);

    // Reset mid-grant (ptr = 3, req bit 1 -> idx 1)
    req4 = 4'b0010; rdy4 = 1'b0;
    step();
    chk("pre_rst_valid", int'(vld4), 1);
    chk("pre_rst_idx", int'(idx4), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(vld4), 0);
    chk("async_rst_idx", int'(idx4), 0);
    req4 = 4'b1000; rdy4 = 1'b1; q4.push_back(3);
    step();
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", int'(vld4), 1);
    req4 = '0;
    step();
    rdy4 = 1'b0;

    // Non-power-of-two width: 0,1,2,0,1
    req3 = 3'b111; rdy3 = 1'b1;
    q3.push_back(0); q3.push_back(1); q3.push_back(2);
    q3.push_back(0); q3.push_back(1);
    repeat (5) step();
    req3 = '0;
    step();
    chk("w3_idle_valid", int'(vld3), 0);
    step();

    chk("w4_queue_drained", q4.size(), 0);
    chk("w3_queue_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
